fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_pkg.sv | 27 ++
 rtl/fetch_slot.sv | 56 +++++
 rtl/fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer: ibus request/response
// structs, the default reset PC and the two-state fetch FSM encoding.
package fetch_ctrl_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_slot.sv
// One-entry output register between fetch and decode. A write always wins;
// otherwise the entry is held while stalled and retired once decode takes it.
module fetch_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  logic [31:0] wr_pc_i,
    input  logic [31:0] wr_instr_i,
    input  logic        wr_adel_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        adel_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        adel_q, adel_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        adel_d  = adel_q;
        if (wr_en_i) begin
            valid_d = 1'b1;
            pc_d    = wr_pc_i;
            instr_d = wr_instr_i;
            adel_d  = wr_adel_i;
        end else if (valid_q && !stall_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            adel_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            adel_q  <= adel_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign adel_o  = adel_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the single-outstanding ibus handshake and
// applies redirects. Optional misaligned-fetch fault via FETCH_ALIGN_CHK_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_adel
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic         discard_q, discard_d;

    logic         req_valid;
    logic         done;
    logic         slot_free;
    logic         misalign;
    logic         slot_wr;
    logic [31:0]  slot_wr_instr;
    logic         slot_wr_adel;

`ifdef FETCH_ALIGN_CHK_EN
    logic         halt_q, halt_d;
    assign misalign = (pc_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Issue only when the slot will be free by the time data returns.
    assign slot_free = !out_valid || !stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        pend_valid_d  = pend_valid_q;
        discard_d     = discard_q;
        req_valid     = 1'b0;
        done          = 1'b0;
        slot_wr       = 1'b0;
        slot_wr_instr = iresp.data;
        slot_wr_adel  = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        halt_d        = halt_q;
`endif
        case (state_q)
            REQ: begin
                req_valid = slot_free && !misalign && !reset;
                if (req_valid && iresp.addr_ok) begin
                    if (iresp.data_ok) begin
                        done = 1'b1;
                    end else begin
                        state_d   = WAIT;
                        discard_d = pend_valid_q || redirect_valid;
                        if (redirect_valid) begin
                            pend_pc_d    = redirect_pc;
                            pend_valid_d = 1'b1;
                        end
                    end
                end else if (req_valid) begin
                    // Address must stay put until accepted; remember the target.
                    if (redirect_valid) begin
                        pend_pc_d    = redirect_pc;
                        pend_valid_d = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_d         = redirect_pc;
                    pend_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                    halt_d       = 1'b0;
`endif
                end else if (pend_valid_q) begin
                    pc_d         = pend_pc_q;
                    pend_valid_d = 1'b0;
                end
`ifdef FETCH_ALIGN_CHK_EN
                else if (misalign && !halt_q && slot_free) begin
                    slot_wr       = 1'b1;
                    slot_wr_instr = '0;
                    slot_wr_adel  = 1'b1;
                    halt_d        = 1'b1;
                end
`endif
            end
            WAIT: begin
                if (iresp.data_ok) begin
                    done = 1'b1;
                end else if (redirect_valid) begin
                    pend_pc_d    = redirect_pc;
                    pend_valid_d = 1'b1;
                    discard_d    = 1'b1;
                end
            end
            default: state_d = REQ;
        endcase

        if (done) begin
            state_d = REQ;
            if (discard_q || pend_valid_q || redirect_valid) begin
                pc_d         = redirect_valid ? redirect_pc : pend_pc_q;
                pend_valid_d = 1'b0;
                discard_d    = 1'b0;
            end else begin
                slot_wr = 1'b1;
                pc_d    = pc_inc(pc_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            discard_q    <= discard_d;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) halt_q <= 1'b0;
        else       halt_q <= halt_d;
    end
`endif

    assign ireq.valid = req_valid;
    assign ireq.addr  = pc_q;

    fetch_slot u_slot (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (slot_wr),
        .wr_pc_i    (pc_q),
        .wr_instr_i (slot_wr_instr),
        .wr_adel_i  (slot_wr_adel),
        .stall_i    (stall),
        .valid_o    (out_valid),
        .pc_o       (out_pc),
        .instr_o    (out_instr),
        .adel_o     (out_adel)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a bus model with programmable addr_ok/data_ok delays
// plus a slot scoreboard fed from completed (non-killed) bus transactions.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] RPC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc, out_instr;
    logic        out_adel;

    fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_adel(out_adel)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } slot_exp_t;
    slot_exp_t exp_q[$];

    int          aok_delay = 0;
    int          dat_delay = 1;
    logic [31:0] dmask = '0;
    logic        pend = 1'b0;
    int          pwait = 0;
    logic [31:0] paddr = '0;
    int          vcnt = 0;
    logic        kill = 1'b0;
    logic [31:0] kill_pc = '0;
    logic [31:0] exp_next = RPC;
    logic        halted = 1'b0;
    int          cyc = 0;
    int          last_acc = -1;
    logic        chk_rate = 1'b0;
    int          n_acc = 0;
    int          n_adel = 0;
    logic [31:0] watch_addr = '0;
    logic        saw = 1'b0;

    task automatic set_next(input logic [31:0] pc);
        slot_exp_t f;
        exp_next = pc;
`ifdef FETCH_ALIGN_CHK_EN
        halted = 1'b0;
        if (pc[1:0] != 2'b00) begin
            f.pc = pc; f.instr = '0; f.adel = 1'b1;
            exp_q.push_back(f);
            halted = 1'b1;
        end
`else
        f.pc = pc; f.instr = '0; f.adel = 1'b0;
`endif
    endtask

    // Bus model and reference: drives iresp on the falling edge, checks the
    // request address and retires slot entries against the scoreboard.
    initial begin
        logic dok, aok;
        slot_exp_t e, n;
        iresp = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                iresp = '0; pend = 1'b0; vcnt = 0; kill = 1'b0; halted = 1'b0;
                exp_next = RPC; last_acc = -1;
                exp_q.delete();
                chk("rst_req_valid", 32'(ireq.valid), 32'd0);
            end else begin
                dok = pend && (pwait == 0);
                aok = ireq.valid && (vcnt >= aok_delay);
                iresp.addr_ok = aok;
                iresp.data_ok = dok;
                iresp.data    = dok ? (paddr ^ dmask) : 32'h0;

                if (out_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        chk("slot_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("slot_pc", out_pc, e.pc);
                        chk("slot_instr", out_instr, e.instr);
                        chk("slot_adel", 32'(out_adel), 32'(e.adel));
                        if (e.adel) n_adel++;
                    end
                end

                if (halted) chk("halt_no_req", 32'(ireq.valid), 32'd0);
                if (ireq.valid) chk("req_addr", ireq.addr, exp_next);

                if (redirect_valid) begin
                    if (ireq.valid || pend) begin
                        kill = 1'b1; kill_pc = redirect_pc;
                    end else begin
                        set_next(redirect_pc);
                    end
                end

                if (dok) begin
                    pend = 1'b0;
                    if (kill) begin
                        kill = 1'b0;
                        set_next(kill_pc);
                    end else begin
                        n.pc = paddr; n.instr = paddr ^ dmask; n.adel = 1'b0;
                        exp_q.push_back(n);
                        set_next(paddr + 32'd4);
                    end
                end else if (pend) begin
                    pwait--;
                end

                if (aok) begin
                    if (chk_rate && last_acc >= 0) chk("rate", 32'(cyc - last_acc), 32'd2);
                    if (ireq.addr == watch_addr) saw = 1'b1;
                    last_acc = cyc; n_acc++;
                    pend = 1'b1; pwait = dat_delay - 1; paddr = ireq.addr; vcnt = 0;
                end else if (ireq.valid) begin
                    vcnt++;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        tick(2);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_adel", 32'(out_adel), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_pend(input int budget);
        int k = 0;
        while (!pend && k < budget) begin tick(); k++; end
        if (!pend) chk("timeout_pend", 32'd0, 32'd1);
    endtask

    task automatic wait_out(input int budget);
        int k = 0;
        while (!out_valid && k < budget) begin tick(); k++; end
        if (!out_valid) chk("timeout_out", 32'd0, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic front(output slot_exp_t e);
        e.pc = '0; e.instr = '0; e.adel = 1'b0;
        if (exp_q.size() > 0) e = exp_q[0];
        else chk("have_exp", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        slot_exp_t e;
        int n0;

        // Zero-wait bus, data == addr: sequential fetch, one per two cycles.
        dmask = '0; aok_delay = 0; dat_delay = 1;
        do_reset();
        n0 = n_acc;
        chk_rate = 1'b1; tick(20); chk_rate = 1'b0;
        chk("t1_progress", 32'(n_acc - n0 >= 9), 32'd1);

        // addr_ok held off 3 cycles: request must stay up with a stable address.
        aok_delay = 3;
        do_reset();
        repeat (4) begin
            @(negedge clk);
            chk("t2_valid_hold", 32'(ireq.valid), 32'd1);
            chk("t2_no_out", 32'(out_valid), 32'd0);
        end
        tick(8);
        aok_delay = 0;

        // Full slot stalled for 5 cycles.
        dmask = 32'h5a5a_0000;
        wait_out(20);
        stall = 1'b1;
        front(e);
        repeat (5) begin
            @(negedge clk);
            chk("t3_pc_hold", out_pc, e.pc);
            chk("t3_instr_hold", out_instr, e.instr);
            chk("t3_no_req", 32'(ireq.valid), 32'd0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        n0 = n_acc;
        tick(8);
        chk("t3_progress", 32'(n_acc > n0), 32'd1);

        // Redirect while waiting for data.
        dat_delay = 3;
        wait_pend(20);
        watch_addr = 32'h8000_0100; saw = 1'b0;
        redirect(32'h8000_0100);
        tick(16);
        chk("t4_target_fetched", 32'(saw), 32'd1);

        // Two redirects before data_ok: newest wins.
        dat_delay = 4;
        wait_pend(20);
        watch_addr = 32'h8000_0300; saw = 1'b0;
        redirect(32'h8000_0200);
        redirect(32'h8000_0300);
        tick(20);
        chk("t5_target_fetched", 32'(saw), 32'd1);

        // Redirects while the slot is full and stalled leave the slot alone.
        dat_delay = 1;
        wait_out(20);
        stall = 1'b1;
        front(e);
        redirect(32'h8000_0400);
        redirect(32'h8000_0500);
        @(negedge clk);
        chk("t5b_valid", 32'(out_valid), 32'd1);
        chk("t5b_pc", out_pc, e.pc);
        chk("t5b_instr", out_instr, e.instr);
        @(posedge clk); #1;
        stall = 1'b0;
        watch_addr = 32'h8000_0500; saw = 1'b0;
        tick(10);
        chk("t5b_target_fetched", 32'(saw), 32'd1);

        // PC wraps past the top of the address space.
        wait_pend(20);
        watch_addr = 32'h0000_0000; saw = 1'b0;
        redirect(32'hffff_fffc);
        tick(10);
        chk("wrap_fetched", 32'(saw), 32'd1);

`ifdef FETCH_ALIGN_CHK_EN
        // Misaligned target: fault entry, fetch halts until the next redirect.
        wait_pend(20);
        n0 = n_adel;
        redirect(32'h8000_0102);
        tick(6);
        chk("t6_adel_slotted", 32'(n_adel - n0), 32'd1);
        @(negedge clk);
        chk("t6_halted", 32'(ireq.valid), 32'd0);
        @(posedge clk); #1;
        watch_addr = 32'h8000_0104; saw = 1'b0;
        redirect(32'h8000_0104);
        tick(10);
        chk("t6_resume", 32'(saw), 32'd1);
`else
        // Without the check, a misaligned target goes to the bus unchanged.
        wait_pend(20);
        watch_addr = 32'h8000_0102; saw = 1'b0;
        redirect(32'h8000_0102);
        tick(8);
        chk("t6_misaligned_fetched", 32'(saw), 32'd1);
        @(negedge clk);
        chk("t6_adel_zero", 32'(out_adel), 32'd0);
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
